// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential shift-and-add multiplier.
//   state_e   : controller state encoding (IDLE / RUN / DONE)
//   width_ok  : legality check for the operand width parameter (2..16)
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic bit width_ok(input int w);
        return (w >= 2) && (w <= 16);
    endfunction

endpackage

// File: rtl/seq_multiplier_rca.sv
// rca_n: parametrised ripple-carry adder, N-bit a + b + cin -> N-bit sum plus carry out.
// Ports:
//   a_i, b_i  in  N   addends
//   cin_i     in  1   carry in
//   sum_o     out N   sum
//   cout_o    out 1   carry out of the top bit
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    // Carry is walked bit by bit through a scalar so the chain stays a plain ripple.
    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one partial product per clock, with a start/busy/done handshake.
// Optional feature macro: SIGNED_MODE_EN (adds is_signed port, two's-complement operands).
// Ports:
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   start      in   1        latch a/b and begin; honoured in IDLE or DONE only
//   a, b       in   WIDTH    multiplicand / multiplier, sampled on accepted start
//   is_signed  in   1        operands are two's complement (SIGNED_MODE_EN only)
//   busy       out  1        high while in RUN
//   done       out  1        one-cycle pulse, product valid
//   product    out  2*WIDTH  registered result, held until the next completion
//
// state   | meaning
// IDLE    | waiting for start, product holds last result
// RUN     | one shift-and-add step per cycle, WIDTH cycles
// DONE    | product just updated, done pulse; start here chains the next operation
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be in 2..16");
    end

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic                 accept;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     op_a, op_b;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     sum_w;
    logic                 cout_w;
    logic [2*WIDTH-1:0]   acc_shift;
    logic [2*WIDTH-1:0]   result;

`ifdef SIGNED_MODE_EN
    logic neg_q;
    logic neg_d;

    // Magnitudes are exact even for -2^(WIDTH-1): negating 100..0 gives 100..0 unsigned.
    assign op_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    assign op_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    assign neg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign result = neg_q ? -acc_shift : acc_shift;
`else
    assign op_a   = a;
    assign op_b   = b;
    assign result = acc_shift;
`endif

    // Multiplier bits live in the low half of acc and shift out through acc[0].
    assign add_b = acc_q[0] ? mcand_q : '0;

    rca_n #(.N(WIDTH)) u_add (
        .a_i   (acc_q[2*WIDTH-1:WIDTH]),
        .b_i   (add_b),
        .cin_i (1'b0),
        .sum_o (sum_w),
        .cout_o(cout_w)
    );

    assign acc_shift = {cout_w, sum_w, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SIGNED_MODE_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q <= op_a;
                acc_q   <= {{WIDTH{1'b0}}, op_b};
                cnt_q   <= '0;
`ifdef SIGNED_MODE_EN
                neg_q   <= neg_d;
`endif
            end else if (state_q == ST_RUN) begin
                acc_q <= acc_shift;
                cnt_q <= cnt_q + CNT_W'(1);
                // The final step's sum goes straight into product on the DONE entry edge.
                if (cnt_q == CNT_LAST) begin
                    product_q <= result;
                end
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and randomized checks of seq_multiplier (WIDTH=4)
// against an arithmetic reference model.
module tb_seq_multiplier;

    localparam int W  = 4;
    localparam int PW = 2 * W;
`ifdef SIGNED_MODE_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
`ifdef SIGNED_MODE_EN
    logic          is_signed;
`endif
    logic          busy, done;
    logic [PW-1:0] product;

    int            errors = 0;
    int            checks = 0;
    logic [PW-1:0] last_p;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef SIGNED_MODE_EN
        .is_signed(is_signed),
`endif
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer multiplication, two's-complement interpretation when signed.
    function automatic logic [PW-1:0] model(input int unsigned x, input int unsigned y, input bit sgn);
        longint sx, sy, p;
        sx = longint'(x);
        sy = longint'(y);
        if (sgn && SIGNED_EN) begin
            if (x >= (1 << (W - 1))) sx = sx - (longint'(1) << W);
            if (y >= (1 << (W - 1))) sy = sy - (longint'(1) << W);
        end
        p = sx * sy;
        return PW'(p);
    endfunction

    // Issue start now (caller is in IDLE or DONE), then follow the operation to its done cycle.
    // poke: RUN cycle (1..W) in which a stray start with other operands is raised; 0 = none.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn, input int poke);
        logic [PW-1:0] exp_p;
        exp_p = model(x, y, sgn);
        a     = x;
        b     = y;
`ifdef SIGNED_MODE_EN
        is_signed = sgn;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            if (i == 1) chk("product_hold_run", product, last_p);
            if (i == poke) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("product", product, exp_p);
        last_p = exp_p;
    endtask

    task automatic idle_chk();
        tick();
        chk("done_idle", done, 0);
        chk("busy_idle", busy, 0);
        chk("product_hold_idle", product, last_p);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
`ifdef SIGNED_MODE_EN
        is_signed = 1'b0;
`endif
        last_p = '0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", busy, 0);

        // Full-scale operands.
        do_op(4'd15, 4'd15, 1'b0, 0);
        chk("e1_const", product, 8'hE1);
        idle_chk();

        // Back-to-back: second start raised in the done cycle, busy next cycle.
        do_op(4'd0, 4'd9, 1'b0, 0);
        do_op(4'd9, 4'd0, 1'b0, 0);
        idle_chk();

        // Stray start mid-RUN is ignored.
        do_op(4'd6, 4'd7, 1'b0, 2);
        chk("ignore_start_const", product, 8'h2A);
        idle_chk();
        chk("no_restart_busy", busy, 0);

        // Reset during RUN aborts with no done pulse.
        a     = 4'd5;
        b     = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        last_p = '0;
        tick();
        chk("abort_no_done", done, 0);
        rst_n = 1'b1;
        repeat (W + 2) begin
            tick();
            chk("abort_idle_done", done, 0);
        end
        do_op(4'd3, 4'd4, 1'b0, 0);
        chk("after_abort_const", product, 8'h0C);
        idle_chk();

`ifdef SIGNED_MODE_EN
        do_op(4'b1000, 4'd7, 1'b1, 0);
        chk("signed_neg56", product, 8'hC8);
        do_op(4'b1000, 4'b1000, 1'b1, 0);
        chk("signed_pos64", product, 8'h40);
        do_op(4'd8, 4'd7, 1'b0, 0);
        chk("unsigned_56", product, 8'h38);
        idle_chk();
`endif

        // Exhaustive sweep, chained back-to-back.
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                do_op(W'(x), W'(y), 1'b0, 0);
            end
        end
        idle_chk();

        // Random operands, sign mode, stray starts and idle gaps.
        for (int n = 0; n < 300; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W)));
            if ($urandom_range(0, 1) == 1) idle_chk();
        end
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
